// File: rtl/id_ex_if.sv
// id_ex_if
//   Bundles the decode stage's pipeline-side signals.
//   master : the surrounding pipeline (IF/ID register, register file, EX control).
//   slave  : the id_ex_stage itself.
//   Inputs to the stage : if_id_valid/instr/pc, rd1, rd2, ex_stall, flush.
//   Outputs of the stage: A1, A2, id_stall and the ID/EX register contents (ex_*).
interface id_ex_if;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        ex_stall;
    logic        flush;

    logic [4:0]  A1;
    logic [4:0]  A2;
    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic [6:0]  ex_opcode;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_alu_src;
    logic        ex_illegal;

    modport master (
        output if_id_valid, if_id_instr, if_id_pc, rd1, rd2, ex_stall, flush,
        input  A1, A2, id_stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_opcode,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump,
               ex_alu_src, ex_illegal
    );

    modport slave (
        input  if_id_valid, if_id_instr, if_id_pc, rd1, rd2, ex_stall, flush,
        output A1, A2, id_stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_opcode,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump,
               ex_alu_src, ex_illegal
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   RV32I decode / operand-fetch stage and the ID/EX pipeline register.
//   Drives register file read addresses, decodes controls and immediates,
//   detects load-use hazards and inserts a single bubble for them.
//   clk   : pipeline clock
//   reset : asynchronous, active-high; clears the ID/EX register
//   bus   : id_ex_if.slave (see id_ex_if.sv for the signal list)
module id_ex_stage (
    input logic   clk,
    input logic   reset,
    id_ex_if.slave bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [6:0]  opcode;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        logic        illegal;
    } id_ex_t;

    // A killed slot keeps its data but must never carry a side effect.
    function automatic id_ex_t kill(input id_ex_t s);
        id_ex_t k;
        k           = s;
        k.valid     = 1'b0;
        k.reg_write = 1'b0;
        k.mem_read  = 1'b0;
        k.mem_write = 1'b0;
        k.branch    = 1'b0;
        k.jump      = 1'b0;
        k.alu_src   = 1'b0;
        k.illegal   = 1'b0;
        return k;
    endfunction

    logic [31:0] instr;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    id_ex_t      dec;
    id_ex_t      ex_d, ex_q;
    logic        uses_rs1, uses_rs2;
    logic        hazard;

    assign instr  = bus.if_id_instr;
    assign bus.A1 = instr[19:15];
    assign bus.A2 = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
        dec          = '0;
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        dec.pc       = bus.if_id_pc;
        dec.rs1_data = bus.rd1;
        dec.rs2_data = bus.rd2;
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        dec.rd       = instr[11:7];
        dec.funct3   = instr[14:12];
        dec.funct7b5 = instr[30];
        dec.opcode   = instr[6:0];

        case (instr[6:0])
            OP_R: begin
                dec.reg_write = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_I_ALU: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = imm_i;
                uses_rs1      = 1'b1;
            end
            OP_LOAD: begin
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = imm_i;
                uses_rs1      = 1'b1;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = imm_s;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.imm    = imm_b;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_JAL: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.imm       = imm_j;
            end
            OP_JALR: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = imm_i;
                uses_rs1      = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = imm_u;
            end
            default: dec.illegal = 1'b1;
        endcase

        // x0 is never written, so EX and forwarding never see it as a destination.
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;

        dec.valid = bus.if_id_valid;
        if (!bus.if_id_valid) dec = kill(dec);
    end

    // Only the load sitting in EX can produce a value too late for forwarding.
    assign hazard = bus.if_id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                    ((uses_rs1 && (ex_q.rd == dec.rs1)) || (uses_rs2 && (ex_q.rd == dec.rs2)));

    assign bus.id_stall = !bus.flush && (bus.ex_stall || hazard);

    always_comb begin
        ex_d = ex_q;
        if (bus.flush)         ex_d = kill(ex_q);
        else if (bus.ex_stall) ex_d = ex_q;
        else if (hazard)       ex_d = kill(ex_q);
        else                   ex_d = dec;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_pc        = ex_q.pc;
    assign bus.ex_rs1_data  = ex_q.rs1_data;
    assign bus.ex_rs2_data  = ex_q.rs2_data;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_rs1       = ex_q.rs1;
    assign bus.ex_rs2       = ex_q.rs2;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_funct3    = ex_q.funct3;
    assign bus.ex_funct7b5  = ex_q.funct7b5;
    assign bus.ex_opcode    = ex_q.opcode;
    assign bus.ex_reg_write = ex_q.reg_write;
    assign bus.ex_mem_read  = ex_q.mem_read;
    assign bus.ex_mem_write = ex_q.mem_write;
    assign bus.ex_branch    = ex_q.branch;
    assign bus.ex_jump      = ex_q.jump;
    assign bus.ex_alu_src   = ex_q.alu_src;
    assign bus.ex_illegal   = ex_q.illegal;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//   Directed vector table for decode plus hand-written sequences for
//   load-use bubbles, downstream stalls, flush and asynchronous reset.
//   The register file is modelled as rdN = 0xA000_0000/0xB000_0000 | address.
module tb_id_ex_stage;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_miscmp;

    id_ex_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.rd1 = 32'hA000_0000 | {27'd0, bus.A1};
    assign bus.rd2 = 32'hB000_0000 | {27'd0, bus.A2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl order: {reg_write, mem_read, mem_write, branch, jump, alu_src, illegal}
    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        exp_valid;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [6:0]  ctrl;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [6:0] ctrl_now();
        return {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_branch,
                bus.ex_jump, bus.ex_alu_src, bus.ex_illegal};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
        bus.if_id_valid = valid;
        bus.if_id_instr = instr;
        bus.if_id_pc    = pc;
    endtask

    initial begin
        logic [31:0] pc;
        int          stall_cycles;

        n_vec    = 0;
        n_miscmp = 0;

        //          instr          v     ev    rd     rs1    rs2    imm            ctrl
        vecs[0]  = '{32'h00500093, 1'b1, 1'b1, 5'd1,  5'd0,  5'd5,  32'h00000005, 7'b1000010}; // addi x1,x0,5
        vecs[1]  = '{32'h0020A423, 1'b1, 1'b1, 5'd8,  5'd1,  5'd2,  32'h00000008, 7'b0010010}; // sw x2,8(x1)
        vecs[2]  = '{32'hFE000EE3, 1'b1, 1'b1, 5'd29, 5'd0,  5'd0,  32'hFFFFFFFC, 7'b0001000}; // beq -4
        vecs[3]  = '{32'h123452B7, 1'b1, 1'b1, 5'd5,  5'd8,  5'd3,  32'h12345000, 7'b1000010}; // lui x5
        vecs[4]  = '{32'h0000007F, 1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  32'h00000000, 7'b0000001}; // illegal
        vecs[5]  = '{32'h00100013, 1'b1, 1'b1, 5'd0,  5'd0,  5'd1,  32'h00000001, 7'b0000010}; // addi x0,x0,1
        vecs[6]  = '{32'h008000EF, 1'b1, 1'b1, 5'd1,  5'd0,  5'd8,  32'h00000008, 7'b1000100}; // jal x1,+8
        vecs[7]  = '{32'h00008067, 1'b1, 1'b1, 5'd0,  5'd1,  5'd0,  32'h00000000, 7'b0000110}; // jalr x0,0(x1)
        vecs[8]  = '{32'hFFFFF197, 1'b1, 1'b1, 5'd3,  5'd31, 5'd31, 32'hFFFFF000, 7'b1000010}; // auipc x3
        vecs[9]  = '{32'h001101B3, 1'b1, 1'b1, 5'd3,  5'd2,  5'd1,  32'h00000000, 7'b1000000}; // add x3,x2,x1
        vecs[10] = '{32'h40208233, 1'b1, 1'b1, 5'd4,  5'd1,  5'd2,  32'h00000000, 7'b1000000}; // sub x4,x1,x2
        vecs[11] = '{32'h00500093, 1'b0, 1'b0, 5'd1,  5'd0,  5'd5,  32'h00000005, 7'b0000000}; // invalid slot
        vecs[12] = '{32'h0000A103, 1'b1, 1'b1, 5'd2,  5'd1,  5'd0,  32'h00000000, 7'b1100010}; // lw x2,0(x1)
        vecs[13] = '{32'hFFF08093, 1'b1, 1'b1, 5'd1,  5'd1,  5'd31, 32'hFFFFFFFF, 7'b1000010}; // addi x1,x1,-1

        // ---------------- reset state ----------------
        reset        = 1'b1;
        bus.ex_stall = 1'b0;
        bus.flush    = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        check("reset ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("reset ex_pc", bus.ex_pc, 32'd0);
        check("reset ex_imm", bus.ex_imm, 32'd0);
        check("reset ctrl", {25'd0, ctrl_now()}, 32'd0);
        check("reset id_stall", {31'd0, bus.id_stall}, 32'd0);
        reset = 1'b0;

        // ---------------- decode table ----------------
        for (int i = 0; i < 14; i++) begin
            pc = 32'h1000 + 32'(i) * 32'd4;
            drive(vecs[i].valid, vecs[i].instr, pc);
            #1;
            check($sformatf("v%0d A1", i), {27'd0, bus.A1}, {27'd0, vecs[i].rs1});
            check($sformatf("v%0d A2", i), {27'd0, bus.A2}, {27'd0, vecs[i].rs2});
            check($sformatf("v%0d id_stall", i), {31'd0, bus.id_stall}, 32'd0);
            tick();
            check($sformatf("v%0d ex_valid", i), {31'd0, bus.ex_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("v%0d ctrl", i), {25'd0, ctrl_now()}, {25'd0, vecs[i].ctrl});
            check($sformatf("v%0d ex_imm", i), bus.ex_imm, vecs[i].imm);
            check($sformatf("v%0d ex_rd", i), {27'd0, bus.ex_rd}, {27'd0, vecs[i].rd});
            check($sformatf("v%0d ex_rs1", i), {27'd0, bus.ex_rs1}, {27'd0, vecs[i].rs1});
            check($sformatf("v%0d ex_rs2", i), {27'd0, bus.ex_rs2}, {27'd0, vecs[i].rs2});
            check($sformatf("v%0d rs1_data", i), bus.ex_rs1_data, 32'hA000_0000 | {27'd0, vecs[i].rs1});
            check($sformatf("v%0d rs2_data", i), bus.ex_rs2_data, 32'hB000_0000 | {27'd0, vecs[i].rs2});
            check($sformatf("v%0d ex_pc", i), bus.ex_pc, pc);
            check($sformatf("v%0d fields", i), {20'd0, bus.ex_opcode, bus.ex_funct3, bus.ex_funct7b5, 1'b0},
                  {20'd0, vecs[i].instr[6:0], vecs[i].instr[14:12], vecs[i].instr[30], 1'b0});
            drive(1'b0, 32'h0, 32'h0);
            tick();
        end

        // ---------------- load-use: exactly one bubble ----------------
        stall_cycles = 0;
        drive(1'b1, 32'h0000A103, 32'h2000);       // lw x2,0(x1)
        tick();
        drive(1'b1, 32'h001101B3, 32'h2004);       // add x3,x2,x1
        for (int c = 0; c < 4; c++) begin
            #1;
            if (bus.id_stall) stall_cycles++;
            tick();
            if (c == 0) begin
                check("lu bubble ex_valid", {31'd0, bus.ex_valid}, 32'd0);
                check("lu bubble ctrl", {25'd0, ctrl_now()}, 32'd0);
            end
            if (c == 1) begin
                check("lu add ex_valid", {31'd0, bus.ex_valid}, 32'd1);
                check("lu add ex_rs1", {27'd0, bus.ex_rs1}, 32'd2);
                check("lu add ex_rs2", {27'd0, bus.ex_rs2}, 32'd1);
                check("lu add ex_pc", bus.ex_pc, 32'h2004);
                drive(1'b1, 32'h00500093, 32'h2008);  // addi x1,x0,5 waits behind the stall
                bus.ex_stall = 1'b1;
                break;
            end
        end
        check("lu stall cycles", 32'(stall_cycles), 32'd1);

        // ---------------- ex_stall held three cycles ----------------
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d id_stall", c), {31'd0, bus.id_stall}, 32'd1);
            tick();
            check($sformatf("stall%0d ex_pc", c), bus.ex_pc, 32'h2004);
            check($sformatf("stall%0d ex_rd", c), {27'd0, bus.ex_rd}, 32'd3);
            check($sformatf("stall%0d ex_rs1_data", c), bus.ex_rs1_data, 32'hA000_0002);
            check($sformatf("stall%0d ctrl", c), {25'd0, ctrl_now()}, 32'b1000000);
            check($sformatf("stall%0d ex_valid", c), {31'd0, bus.ex_valid}, 32'd1);
        end
        bus.ex_stall = 1'b0;
        #1;
        check("release id_stall", {31'd0, bus.id_stall}, 32'd0);
        tick();
        check("release ex_rd", {27'd0, bus.ex_rd}, 32'd1);
        check("release ex_imm", bus.ex_imm, 32'd5);
        check("release ex_pc", bus.ex_pc, 32'h2008);

        // ---------------- hazard during ex_stall: still one bubble ----------------
        drive(1'b1, 32'h0000A103, 32'h3000);       // lw x2
        tick();
        drive(1'b1, 32'h001101B3, 32'h3004);       // add x3,x2,x1
        bus.ex_stall = 1'b1;
        tick();
        check("hs hold mem_read", {31'd0, bus.ex_mem_read}, 32'd1);
        bus.ex_stall = 1'b0;
        #1;
        check("hs id_stall", {31'd0, bus.id_stall}, 32'd1);
        tick();
        check("hs bubble", {31'd0, bus.ex_valid}, 32'd0);
        tick();
        check("hs add captured", {27'd0, bus.ex_rd} | {31'd0, bus.ex_valid} << 8, 32'h103);

        // ---------------- flush with a load-use hazard ----------------
        drive(1'b1, 32'h0000A103, 32'h4000);       // lw x2
        tick();
        drive(1'b1, 32'h001101B3, 32'h4004);       // add x3,x2,x1 (hazard)
        bus.flush = 1'b1;
        #1;
        check("flush id_stall", {31'd0, bus.id_stall}, 32'd0);
        tick();
        check("flush ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("flush ctrl", {25'd0, ctrl_now()}, 32'd0);
        bus.flush = 1'b0;
        drive(1'b1, 32'h00500093, 32'h4100);       // target: addi x1,x0,5
        #1;
        check("post-flush id_stall", {31'd0, bus.id_stall}, 32'd0);
        tick();
        check("post-flush ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("post-flush ex_pc", bus.ex_pc, 32'h4100);

        // ---------------- async reset mid-stall ----------------
        bus.ex_stall = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("areset ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("areset ex_pc", bus.ex_pc, 32'd0);
        check("areset ex_imm", bus.ex_imm, 32'd0);
        check("areset ex_rd", {27'd0, bus.ex_rd}, 32'd0);
        check("areset ctrl", {25'd0, ctrl_now()}, 32'd0);
        tick();
        reset        = 1'b0;
        bus.ex_stall = 1'b0;
        drive(1'b1, 32'h00500093, 32'h5000);
        tick();
        check("fresh ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("fresh ex_rd", {27'd0, bus.ex_rd}, 32'd1);
        check("fresh ex_pc", bus.ex_pc, 32'h5000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
